// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer and
// per-thread selective flush. Outputs come straight from registered state.
//
// state | meaning
// EMPTY | m_valid=0, s_valid=0: nothing held, ready for a beat
// ONE   | m_valid=1, s_valid=0: main drives ID, skid free
// FULL  | m_valid=1, s_valid=1: both held, in_ready low
module if_id_skid_stage #(
    parameter int PC_W    = 10,
    parameter int TID_W   = 2,
    parameter int INSTR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [TID_W-1:0]        in_tid,
    input  logic [INSTR_W-1:0]      in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [TID_W-1:0]        out_tid,
    output logic [INSTR_W-1:0]      out_instr,
    input  logic                    flush,
    input  logic [(2**TID_W)-1:0]   flush_mask,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    logic               m_valid, s_valid;
    logic [PC_W-1:0]    m_pc, s_pc;
    logic [TID_W-1:0]   m_tid, s_tid;
    logic [INSTR_W-1:0] m_instr, s_instr;

    logic               nxt_m_valid, nxt_s_valid;
    logic [PC_W-1:0]    nxt_m_pc, nxt_s_pc;
    logic [TID_W-1:0]   nxt_m_tid, nxt_s_tid;
    logic [INSTR_W-1:0] nxt_m_instr, nxt_s_instr;

    logic   accept, deliver;
    logic   m_kill, s_kill, in_kill;
    logic   keep_m, keep_s, keep_i;
    state_t state;

    assign state = state_t'({s_valid, m_valid});

    // State register: valid bits plus the data held in each slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_pc    <= '0;
            m_tid   <= '0;
            m_instr <= '0;
            s_pc    <= '0;
            s_tid   <= '0;
            s_instr <= '0;
        end else begin
            m_valid <= nxt_m_valid;
            s_valid <= nxt_s_valid;
            m_pc    <= nxt_m_pc;
            m_tid   <= nxt_m_tid;
            m_instr <= nxt_m_instr;
            s_pc    <= nxt_s_pc;
            s_tid   <= nxt_s_tid;
            s_instr <= nxt_s_instr;
        end
    end

    assign accept  = in_valid && in_ready;
    assign deliver = m_valid && out_ready;

    assign m_kill  = flush && flush_mask[m_tid];
    assign s_kill  = flush && flush_mask[s_tid];
    assign in_kill = flush && flush_mask[in_tid];

    // Survivors in age order: main, skid, incoming. Accept only happens with
    // skid empty, so at most two survive and they compact toward main.
    assign keep_m = m_valid && !deliver && !m_kill;
    assign keep_s = s_valid && !s_kill;
    assign keep_i = accept && !in_kill;

    // Next-state: data fields keep their old value when a slot empties.
    always_comb begin
        nxt_m_valid = 1'b0;
        nxt_s_valid = 1'b0;
        nxt_m_pc    = m_pc;
        nxt_m_tid   = m_tid;
        nxt_m_instr = m_instr;
        nxt_s_pc    = s_pc;
        nxt_s_tid   = s_tid;
        nxt_s_instr = s_instr;

        if (keep_m) begin
            nxt_m_valid = 1'b1;
            if (keep_s) begin
                nxt_s_valid = 1'b1;
            end else if (keep_i) begin
                nxt_s_valid = 1'b1;
                nxt_s_pc    = in_pc;
                nxt_s_tid   = in_tid;
                nxt_s_instr = in_instr;
            end
        end else if (keep_s) begin
            nxt_m_valid = 1'b1;
            nxt_m_pc    = s_pc;
            nxt_m_tid   = s_tid;
            nxt_m_instr = s_instr;
            if (keep_i) begin
                nxt_s_valid = 1'b1;
                nxt_s_pc    = in_pc;
                nxt_s_tid   = in_tid;
                nxt_s_instr = in_instr;
            end
        end else if (keep_i) begin
            nxt_m_valid = 1'b1;
            nxt_m_pc    = in_pc;
            nxt_m_tid   = in_tid;
            nxt_m_instr = in_instr;
        end
    end

    // Outputs depend only on registered state.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
        case (state)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                occupancy = 2'd0;
            end
            ONE: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = 2'd2;
            end
            default: begin
                // Unreachable skid-only encoding: stall intake, report the held beat.
                out_valid = 1'b0;
                in_ready  = 1'b0;
                occupancy = 2'd1;
            end
        endcase
    end

    assign out_pc    = m_pc;
    assign out_tid   = m_tid;
    assign out_instr = m_instr;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed vector table, streaming sequence and random soak against a queue model.
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_pc;
    logic [1:0]  in_tid;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_pc;
    logic [1:0]  out_tid;
    logic [31:0] out_instr;
    logic        flush;
    logic [3:0]  flush_mask;
    logic [1:0]  occupancy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail_print = 0;

    always #5 clk = ~clk;

    if_id_skid_stage #(.PC_W(10), .TID_W(2), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_tid(in_tid), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_tid(out_tid), .out_instr(out_instr),
        .flush(flush), .flush_mask(flush_mask), .occupancy(occupancy)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [9:0]  pc;
        logic [1:0]  tid;
        logic        ordy;
        logic        fl;
        logic [3:0]  mask;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [9:0]  e_pc;
        logic [1:0]  e_tid;
        logic [31:0] e_instr;
    } vec_t;

    typedef struct {
        logic [9:0] pc;
        logic [1:0] tid;
    } beat_t;

    function automatic logic [31:0] instr_of(input logic [9:0] pc);
        return {12'hA5C, 10'd0, pc};
    endfunction

    function automatic vec_t mk(input logic r, input logic iv, input logic [9:0] pc,
                                input logic [1:0] tid, input logic ordy, input logic fl,
                                input logic [3:0] mask, input logic e_ov, input logic e_ir,
                                input logic [1:0] e_occ, input logic [9:0] e_pc,
                                input logic [1:0] e_tid);
        vec_t v;
        v.rst = r; v.iv = iv; v.pc = pc; v.tid = tid; v.ordy = ordy;
        v.fl = fl; v.mask = mask; v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
        v.e_pc = e_pc; v.e_tid = e_tid;
        v.e_instr = r ? 32'd0 : instr_of(e_pc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            if (n_fail_print < 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            n_fail_print++;
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [9:0] pc,
                         input logic [1:0] tid, input logic ordy, input logic fl,
                         input logic [3:0] mask);
        rst = r; in_valid = iv; in_pc = pc; in_tid = tid; in_instr = instr_of(pc);
        out_ready = ordy; flush = fl; flush_mask = mask;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.rst, v.iv, v.pc, v.tid, v.ordy, v.fl, v.mask);
        @(posedge clk);
        #1;
        chk($sformatf("row%0d out_valid", idx), 64'(out_valid), 64'(v.e_ov));
        chk($sformatf("row%0d in_ready", idx), 64'(in_ready), 64'(v.e_ir));
        chk($sformatf("row%0d occupancy", idx), 64'(occupancy), 64'(v.e_occ));
        chk($sformatf("row%0d out_pc", idx), 64'(out_pc), 64'(v.e_pc));
        chk($sformatf("row%0d out_tid", idx), 64'(out_tid), 64'(v.e_tid));
        chk($sformatf("row%0d out_instr", idx), 64'(out_instr), 64'(v.e_instr));
    endtask

    vec_t  vecs[$];
    beat_t q[$];

    initial begin
        drive(1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 4'd0);

        // Reset, then stream 16 beats at full rate.
        vecs.push_back(mk(1,0,10'h000,0,0,0,4'h0, 0,1,0,10'h000,0));
        run_row(vecs[0], 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 10'(i), 2'(i % 4), 1'b1, 1'b0, 4'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d out_pc", i), 64'(out_pc), 64'(i));
            chk($sformatf("stream%0d out_tid", i), 64'(out_tid), 64'(i % 4));
            chk($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
        end

        vecs.delete();
        // Drain after stream.
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 0,1,0,10'h00F,3));
        // Backpressure.
        vecs.push_back(mk(0,1,10'h010,0,0,0,4'h0, 1,1,1,10'h010,0));
        vecs.push_back(mk(0,1,10'h011,1,0,0,4'h0, 1,0,2,10'h010,0));
        vecs.push_back(mk(0,0,10'h000,0,0,0,4'h0, 1,0,2,10'h010,0));
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 1,1,1,10'h011,1));
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 0,1,0,10'h011,1));
        // Selective flush in FULL kills main, skid moves up.
        vecs.push_back(mk(0,1,10'h020,1,0,0,4'h0, 1,1,1,10'h020,1));
        vecs.push_back(mk(0,1,10'h021,2,0,0,4'h0, 1,0,2,10'h020,1));
        vecs.push_back(mk(0,0,10'h000,0,0,1,4'h2, 1,1,1,10'h021,2));
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 0,1,0,10'h021,2));
        // Flush of incoming beat, then a non-matching mask.
        vecs.push_back(mk(0,1,10'h030,3,0,1,4'h8, 0,1,0,10'h021,2));
        vecs.push_back(mk(0,1,10'h030,3,0,1,4'h1, 1,1,1,10'h030,3));
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 0,1,0,10'h030,3));
        // Reset while FULL with accept and flush pending.
        vecs.push_back(mk(0,1,10'h040,0,0,0,4'h0, 1,1,1,10'h040,0));
        vecs.push_back(mk(0,1,10'h041,1,0,0,4'h0, 1,0,2,10'h040,0));
        vecs.push_back(mk(1,1,10'h042,2,0,1,4'hF, 0,1,0,10'h000,0));
        // Zero mask is a no-op, full mask empties.
        vecs.push_back(mk(0,1,10'h050,0,0,0,4'h0, 1,1,1,10'h050,0));
        vecs.push_back(mk(0,1,10'h051,3,0,0,4'h0, 1,0,2,10'h050,0));
        vecs.push_back(mk(0,0,10'h000,0,0,1,4'h0, 1,0,2,10'h050,0));
        vecs.push_back(mk(0,0,10'h000,0,0,1,4'hF, 0,1,0,10'h050,0));
        // Flush with deliver and accept: survivor placement.
        vecs.push_back(mk(0,1,10'h060,2,0,0,4'h0, 1,1,1,10'h060,2));
        vecs.push_back(mk(0,1,10'h061,1,1,1,4'h4, 1,1,1,10'h061,1));
        vecs.push_back(mk(0,1,10'h062,0,0,1,4'h2, 1,1,1,10'h062,0));
        vecs.push_back(mk(0,1,10'h063,1,0,1,4'h2, 1,1,1,10'h062,0));
        vecs.push_back(mk(0,0,10'h000,0,1,0,4'h0, 0,1,0,10'h062,0));
        foreach (vecs[i]) run_row(vecs[i], i + 1);

        // Random soak against a queue model; stage is empty here.
        begin
            logic       held = 1'b0;
            logic [9:0] next_pc = 10'h100;
            int         max_occ = 0;
            q.delete();
            for (int c = 0; c < 10000; c++) begin
                logic acc, dlv;
                beat_t b;
                @(negedge clk);
                if (q.size() > 0)
                    chk("soak data", {32'd0, out_pc, out_tid, out_instr},
                        {32'd0, q[0].pc, q[0].tid, instr_of(q[0].pc)});
                chk("soak ctrl", 64'({out_valid, in_ready, occupancy}),
                    64'({q.size() > 0, q.size() < 2, 2'(q.size())}));
                if (!held) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_pc    = next_pc;
                    in_tid   = 2'($urandom_range(0, 3));
                    in_instr = instr_of(next_pc);
                end
                out_ready  = ($urandom_range(0, 2) != 0);
                flush      = ($urandom_range(0, 7) == 0);
                flush_mask = 4'($urandom_range(0, 15));
                rst        = 1'b0;

                acc = in_valid && (q.size() < 2);
                dlv = (q.size() > 0) && out_ready;
                held = in_valid && !acc;
                if (acc) next_pc = next_pc + 10'd1;
                if (dlv) void'(q.pop_front());
                if (flush) begin
                    for (int k = q.size() - 1; k >= 0; k--)
                        if (flush_mask[q[k].tid]) q.delete(k);
                end
                if (acc && !(flush && flush_mask[in_tid])) begin
                    b.pc = in_pc;
                    b.tid = in_tid;
                    q.push_back(b);
                end
                if (q.size() > max_occ) max_occ = q.size();
            end
            chk("soak model bound", 64'(max_occ <= 2), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Next-generation IF/ID pipeline register for the multithreaded core.
- Carries pc, thread id and fetched instruction from IF to ID.
- Replaces the bare enable-gated register with a valid/ready handshake and a 2-entry skid buffer, so that ID backpressure never drops or duplicates a fetch.
- Adds per-thread selective flush for branch redirect, and full parametrisation of pc, thread-id and instruction widths.

Parameters:
- PC_W, 10, width of program counter.
- TID_W, 2, thread id width; thread count is NT = 2**TID_W.
- INSTR_W, 32, instruction word width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  IF presents a fetch beat.
- in_ready  output  1  stage can accept a beat this cycle.
- in_pc  input  PC_W  fetch pc.
- in_tid  input  TID_W  fetch thread id.
- in_instr  input  INSTR_W  fetched instruction.
- out_valid  output  1  beat available to ID.
- out_ready  input  1  ID consumes the beat this cycle.
- out_pc  output  PC_W  pc to ID.
- out_tid  output  TID_W  thread id to ID.
- out_instr  output  INSTR_W  instruction to ID.
- flush  input  1  kill in-flight beats of the selected threads.
- flush_mask  input  NT  one bit per thread; bit t set means kill tid t.
- occupancy  output  2  number of held beats (0, 1 or 2).

Behaviour:
- Storage:
  - main entry (m_valid, m_pc, m_tid, m_instr) drives the out_* ports directly.
  - skid entry (s_valid, s_pc, s_tid, s_instr).
- Derived signals:
  - out_valid = m_valid.
  - in_ready = !s_valid.
  - occupancy = m_valid + s_valid.
  - All are registered-state derived; there is no combinational in->out path.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Deliver = out_valid && out_ready.
  - IF must hold data stable while in_valid && !in_ready.
- States (derived from valid bits): EMPTY (0,0), ONE (1,0), FULL (1,1). The state (m=0, s=1) is illegal and never reached.
- Transitions without flush:
  - EMPTY + accept -> ONE; the beat loads main.
  - ONE + accept + deliver -> ONE; the beat loads main.
  - ONE + accept, no deliver -> FULL; the beat loads skid.
  - ONE + deliver, no accept -> EMPTY.
  - FULL + deliver -> ONE; skid moves to main. No accept is possible in FULL.
  - Any other case: hold.
- Ordering: beats leave in exact acceptance order. Skid is always younger than main.
- Latency:
  - Accept at edge N -> out_valid at N+1 (1-cycle latency).
  - Sustained throughput is 1 beat/cycle while out_ready stays high.
- Flush, applied in the cycle flush=1 and effective at the next edge:
  - Kill every held entry whose tid bit is set in flush_mask.
  - An accepted beat whose tid bit is set is taken (handshake completes) but discarded.
  - A beat delivered in the flush cycle counts as delivered; ID applies the same flush to it.
  - Survivors compact toward main, preserving order.
  - If main is killed and skid survives, skid moves to main.
  - A surviving accepted beat goes to main if main is empty after the kill/deliver, otherwise to skid.
- Flush with flush_mask all ones empties the stage at the next edge.
- Flush with flush_mask all zeros is a no-op.
- Reset:
  - m_valid = s_valid = 0; all data fields cleared to 0.
  - Outputs after reset: out_valid=0, in_ready=1, occupancy=0, out_pc=0, out_tid=0, out_instr=0.
  - Reset dominates accept, deliver and flush in the same cycle, including reset while FULL.
- Data fields hold their last loaded value when invalid. They are never X after reset.
- No width arithmetic beyond the occupancy sum, which is 2 bits and cannot overflow.

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, pcs 0x000..0x00F with tid cycling 0..3.
  - Required: out pcs in order, first at 1 cycle latency, 16 beats in 16 cycles, in_ready constantly 1.
- Backpressure: out_ready=0 while feeding pc 0x010, 0x011.
  - Required: occupancy 1 then 2, in_ready=0, out_pc held at 0x010.
  - Then out_ready=1: 0x010 then 0x011 delivered, in_ready returns to 1, no loss or duplicate.
- Selective flush in FULL: main pc 0x020 tid1, skid pc 0x021 tid2, flush=1, flush_mask=4'b0010, out_ready=0.
  - Required next cycle: occupancy=1, out_pc=0x021, out_tid=2.
- Flush of incoming beat: stage EMPTY, in_valid=1 pc 0x030 tid3, flush=1, flush_mask=4'b1000.
  - Required: in_ready=1 (accepted), next cycle out_valid=0.
  - Repeat with mask 4'b0001: out_pc=0x030 appears.
- Reset mid-operation: FULL with out_ready=0, assert rst for 1 cycle together with in_valid=1 and flush=1.
  - Required: next cycle out_valid=0, occupancy=0, in_ready=1, out_pc=0, out_tid=0, out_instr=0.
- Random valid/ready/flush soak, 10k cycles, against a scoreboard queue model.
  - Required: order preserved, only unflushed beats delivered, occupancy never exceeds 2.
